arbiter_burst_mux: RTL

Downstream stage of the 1-cycle interleaved weighted round-robin arbiter. Consumes the arbiter's one-hot grant, returns its grant-ready handshake and burst-size charge, then forwards a whole burst of beats from the granted requester onto one shared valid/ready output channel. Output is fully registered. Bursts from different requesters never interleave.

---
 rtl/arbiter_burst_pkg.sv | 15 +
 rtl/arb_onehot_enc.sv | 22 ++
 rtl/arbiter_burst_mux.sv | 137 +++++++++++++
 3 files changed

// File: rtl/arbiter_burst_pkg.sv
// Shared state encoding and ID-width helper for the burst mux that sits behind
// the interleaved weighted round-robin arbiter.
package arbiter_burst_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } burst_state_e;

    // A single requester still needs a 1-bit ID field.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/arb_onehot_enc.sv
// One-hot to binary encoder; if several bits are set, the lowest one wins.
module arb_onehot_enc #(
    parameter int P_N     = 4,
    parameter int P_IDX_W = 2
) (
    input  logic [P_N-1:0]     onehot_i,
    output logic [P_IDX_W-1:0] idx_o,
    output logic               any_o
);

    always_comb begin
        idx_o = '0;
        for (int i = P_N - 1; i >= 0; i--) begin
            if (onehot_i[i]) begin
                idx_o = P_IDX_W'(i);
            end
        end
    end

    assign any_o = |onehot_i;

endmodule

// File: rtl/arbiter_burst_mux.sv
// Burst mux behind the WRR arbiter: accepts a grant, then forwards L+1 beats of
// the granted requester onto one registered valid/ready channel.
// ARBITER_BURST_MUX_FASTGRANT_EN: accept the next grant on the last beat (no bubble).
//
// state   | meaning
// ST_IDLE | no burst active; any grant is accepted this cycle
// ST_XFER | forwarding beats of requester sel_q, cnt_q beats left after this one
module arbiter_burst_mux
    import arbiter_burst_pkg::*;
#(
    parameter int P_REQUESTER_NUM   = 4,
    parameter int P_DATA_W          = 32,
    parameter int P_NUM_GRANT_REQ_W = 3
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  logic [P_REQUESTER_NUM-1:0]                   grant_valid_i,
    output logic                                         grant_ready_o,
    output logic [P_NUM_GRANT_REQ_W-1:0]                 num_grant_req_o,
    input  logic [P_REQUESTER_NUM*P_NUM_GRANT_REQ_W-1:0] req_len_i,
    input  logic [P_REQUESTER_NUM-1:0]                   s_valid_i,
    input  logic [P_REQUESTER_NUM*P_DATA_W-1:0]          s_data_i,
    output logic [P_REQUESTER_NUM-1:0]                   s_ready_o,
    output logic                                         m_valid_o,
    output logic [P_DATA_W-1:0]                          m_data_o,
    output logic [id_width(P_REQUESTER_NUM)-1:0]         m_id_o,
    output logic                                         m_last_o,
    input  logic                                         m_ready_i
);

    localparam int ID_W  = id_width(P_REQUESTER_NUM);
    localparam int LEN_W = P_NUM_GRANT_REQ_W;

    burst_state_e          state_q, state_d;
    logic [ID_W-1:0]       sel_q, sel_d;
    logic [LEN_W-1:0]      cnt_q, cnt_d;

    logic                  m_valid_q;
    logic [P_DATA_W-1:0]   m_data_q;
    logic [ID_W-1:0]       m_id_q;
    logic                  m_last_q;

    logic [ID_W-1:0]       grant_idx;
    logic                  grant_any;
    logic [LEN_W-1:0]      grant_len;
    logic                  slot_free;
    logic                  beat_acc;

    arb_onehot_enc #(
        .P_N     (P_REQUESTER_NUM),
        .P_IDX_W (ID_W)
    ) u_grant_enc (
        .onehot_i (grant_valid_i),
        .idx_o    (grant_idx),
        .any_o    (grant_any)
    );

    assign grant_len       = grant_any ? req_len_i[int'(grant_idx)*LEN_W +: LEN_W] : '0;
    assign num_grant_req_o = grant_len;
    assign slot_free       = ~m_valid_q | m_ready_i;

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        cnt_d         = cnt_q;
        grant_ready_o = 1'b0;
        s_ready_o     = '0;
        beat_acc      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                grant_ready_o = grant_any;
                if (grant_any) begin
                    sel_d   = grant_idx;
                    cnt_d   = grant_len;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                s_ready_o[sel_q] = slot_free;
                beat_acc         = s_valid_i[sel_q] & slot_free;
                if (beat_acc) begin
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
`ifdef ARBITER_BURST_MUX_FASTGRANT_EN
                        // Chain straight into the next burst without an IDLE cycle.
                        grant_ready_o = grant_any;
                        if (grant_any) begin
                            sel_d   = grant_idx;
                            cnt_d   = grant_len;
                            state_d = ST_XFER;
                        end
`endif
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    // Output slot: load on accept, drain on ready, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_id_q    <= '0;
            m_last_q  <= 1'b0;
        end else if (beat_acc) begin
            m_valid_q <= 1'b1;
            m_data_q  <= s_data_i[int'(sel_q)*P_DATA_W +: P_DATA_W];
            m_id_q    <= sel_q;
            m_last_q  <= (cnt_q == '0);
        end else if (m_ready_i) begin
            m_valid_q <= 1'b0;
        end
    end

    assign m_valid_o = m_valid_q;
    assign m_data_o  = m_data_q;
    assign m_id_o    = m_id_q;
    assign m_last_o  = m_last_q;

endmodule
